// File: rtl/gb_fb_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : gb_fb_writer
//  Purpose  : Packs the 2-bit PPU pixel stream (160x144) into bytes of four
//             pixels and writes them into a double-buffered framebuffer.
//             A bank is published through frame_sel only when a complete
//             frame has been written into it.
//  Options  : GB_FB_ERRCNT_EN - when defined, err_cnt counts malformed
//             lines and dropped frames (saturating); otherwise it is tied
//             to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module gb_fb_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ppu_vs,
  input  logic        ppu_hs,
  input  logic        ppu_de,
  input  logic [1:0]  ppu_color,
  output logic        fb_we,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        frame_sel,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  c_X_MAX     = 8'd160;
  localparam logic [7:0]  c_Y_MAX     = 8'd144;
  localparam logic [12:0] c_LINE_BYTES = 13'd40;

  typedef enum logic [0:0] {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        vs_q, hs_q;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [7:0]  pack_q, pack_d;
  logic [12:0] base_q, base_d;
  logic        bank_q, bank_d;
  logic        fsel_q, fsel_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;

  logic        w_vs_rise;
  logic        w_hs_rise;
  logic [12:0] w_offset;

  // Edge detect: current input level against the previous registered sample.
  assign w_vs_rise = ppu_vs & ~vs_q;
  assign w_hs_rise = ppu_hs & ~hs_q;
  // Byte offset of the group x currently falls into.
  assign w_offset  = base_q + {7'd0, x_q[7:2]};

`ifdef GB_FB_ERRCNT_EN
  logic       w_bad;
  logic [7:0] err_q;
`endif

  // Next-state logic: sync handling, pixel packing, line flush, frame commit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pcnt_d  = pcnt_q;
    pack_d  = pack_q;
    base_d  = base_q;
    bank_d  = bank_q;
    fsel_d  = fsel_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
`ifdef GB_FB_ERRCNT_EN
    w_bad   = 1'b0;
`endif
    case (state_q)
      SYNC: begin
        if (w_vs_rise) begin
          state_d = ACTIVE;
          x_d     = 8'd0;
          y_d     = 8'd0;
          base_d  = 13'd0;
          pcnt_d  = 2'd0;
        end
      end
      default: begin
        if (w_vs_rise) begin
          // Frame boundary wins over a coincident line boundary.
          if (y_q == c_Y_MAX) begin
            done_d = 1'b1;
            fsel_d = bank_q;
            bank_d = ~bank_q;
          end else begin
`ifdef GB_FB_ERRCNT_EN
            w_bad = 1'b1;
`endif
          end
          x_d    = 8'd0;
          y_d    = 8'd0;
          base_d = 13'd0;
          pcnt_d = 2'd0;
        end else if (w_hs_rise) begin
          if (pcnt_q != 2'd0) begin
            // Flush the partial group, padding missing pixels with shade 0.
            we_d   = 1'b1;
            addr_d = {bank_q, w_offset};
            case (pcnt_q)
              2'd1:    wdata_d = {pack_q[1:0], 6'd0};
              2'd2:    wdata_d = {pack_q[3:0], 4'd0};
              default: wdata_d = {pack_q[5:0], 2'd0};
            endcase
          end
          if ((x_q != 8'd0) && (y_q != c_Y_MAX)) begin
            y_d    = y_q + 8'd1;
            base_d = base_q + c_LINE_BYTES;
          end
          if ((x_q != 8'd0) && (x_q != c_X_MAX)) begin
`ifdef GB_FB_ERRCNT_EN
            w_bad = 1'b1;
`endif
          end
          x_d    = 8'd0;
          pcnt_d = 2'd0;
        end else if (ppu_de && (x_q < c_X_MAX) && (y_q < c_Y_MAX)) begin
          pack_d = {pack_q[5:0], ppu_color};
          x_d    = x_q + 8'd1;
          pcnt_d = pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {bank_q, w_offset};
            wdata_d = {pack_q[5:0], ppu_color};
          end
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      pcnt_q  <= 2'd0;
      pack_q  <= 8'd0;
      base_q  <= 13'd0;
      bank_q  <= 1'b0;
      fsel_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 14'd0;
      wdata_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= ppu_vs;
      hs_q    <= ppu_hs;
      x_q     <= x_d;
      y_q     <= y_d;
      pcnt_q  <= pcnt_d;
      pack_q  <= pack_d;
      base_q  <= base_d;
      bank_q  <= bank_d;
      fsel_q  <= fsel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

`ifdef GB_FB_ERRCNT_EN
  // Saturating count of malformed lines and dropped frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (w_bad && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_wdata   = wdata_q;
  assign frame_sel  = fsel_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_fb_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gb_fb_writer
//  Purpose  : Self-checking bench for gb_fb_writer: reset values, short and
//             malformed lines, dropped and committed frames, bank toggling,
//             coincident syncs and reset mid-line. Follows GB_FB_ERRCNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_fb_writer;

  logic        clk = 1'b0;
  logic        rst, vs, hs, de;
  logic [1:0]  color;
  logic        fb_we, frame_sel, frame_done;
  logic [13:0] fb_addr;
  logic [7:0]  fb_wdata, err_cnt;

  int checks = 0;
  int failures = 0;
  logic [21:0] wq[$];   // {fb_addr, fb_wdata} of every write strobe
  int done_cnt = 0;
  logic [7:0] exp_err = 8'd0;

  gb_fb_writer dut (
    .clk(clk), .rst(rst), .ppu_vs(vs), .ppu_hs(hs), .ppu_de(de),
    .ppu_color(color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_sel(frame_sel), .frame_done(frame_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Record writes and frame pulses midway between rising edges.
  always @(negedge clk) begin
    if (fb_we === 1'b1) wq.push_back({fb_addr, fb_wdata});
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bad();
`ifdef GB_FB_ERRCNT_EN
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
`endif
  endtask

  // mode < 0: shades cycle 0,1,2,3; otherwise constant shade 'mode'.
  task automatic pixels(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      color = (mode < 0) ? 2'(i % 4) : 2'(mode);
      tick();
    end
    de = 1'b0;
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick(); hs = 1'b0; tick(); tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick(); vs = 1'b0; tick(); tick();
  endtask

  task automatic line(input int n, input int mode);
    pixels(n, mode);
    hs_pulse();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fb_we"}, fb_we, 0);
    check({tag, " fb_addr"}, fb_addr, 0);
    check({tag, " fb_wdata"}, fb_wdata, 0);
    check({tag, " frame_sel"}, frame_sel, 1);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " err_cnt"}, err_cnt, 0);
  endtask

  // One full 160x144 frame of repeating shades 0..3, then commit.
  task automatic full_frame(input logic bank);
    int mark, d0, bad_d, bad_a;
    logic [13:0] last;
    mark = wq.size();
    d0 = done_cnt;
    bad_d = 0;
    bad_a = 0;
    for (int l = 0; l < 144; l++) line(160, -1);
    vs_pulse();
    for (int i = mark; i < wq.size(); i++) begin
      if (wq[i][7:0] != 8'h1B) bad_d++;
      if (wq[i][21:8] != {bank, 13'(i - mark)}) bad_a++;
    end
    last = (wq.size() > mark) ? wq[wq.size()-1][21:8] : 14'd0;
    check("frame writes", wq.size() - mark, 5760);
    check("frame bad data", bad_d, 0);
    check("frame bad addr", bad_a, 0);
    check("frame last addr", last, bank ? 14'h367F : 14'h167F);
    check("frame_done pulses", done_cnt - d0, 1);
    check("frame_sel", frame_sel, bank);
    check("frame err_cnt", err_cnt, exp_err);
  endtask

  typedef struct {
    int          npix;
    int          col;
    int          nwr;
    logic [7:0]  d0;
    logic [12:0] o0;
    logic [7:0]  d1;
    logic [12:0] o1;
    bit          malformed;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int mark, d0;
    // Lines within one frame; offsets follow line_base = 40 * lines with x != 0.
    tbl[0] = '{6,   3, 2,  8'hFF, 13'd0,   8'hF0, 13'd1,   1'b1};
    tbl[1] = '{160, 2, 40, 8'hAA, 13'd40,  8'hAA, 13'd79,  1'b0};
    tbl[2] = '{1,   1, 1,  8'h40, 13'd80,  8'h40, 13'd80,  1'b1};
    tbl[3] = '{3,   2, 1,  8'hA8, 13'd120, 8'hA8, 13'd120, 1'b1};
    tbl[4] = '{0,   0, 0,  8'h00, 13'd0,   8'h00, 13'd0,   1'b0};
    tbl[5] = '{4,   1, 1,  8'h55, 13'd160, 8'h55, 13'd160, 1'b1};
    tbl[6] = '{2,   3, 1,  8'hF0, 13'd200, 8'hF0, 13'd200, 1'b1};

    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; color = 2'd0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Pixels before the first frame start are discarded.
    mark = wq.size();
    pixels(8, 3);
    hs_pulse();
    check("pre-sync writes", wq.size() - mark, 0);
    check("pre-sync err_cnt", err_cnt, 0);

    vs_pulse();

    for (int i = 0; i < 7; i++) begin
      mark = wq.size();
      line(tbl[i].npix, tbl[i].col);
      if (tbl[i].malformed) bad();
      check($sformatf("vec%0d writes", i), wq.size() - mark, tbl[i].nwr);
      if (tbl[i].nwr > 0 && wq.size() > mark) begin
        check($sformatf("vec%0d first", i), wq[mark], {1'b0, tbl[i].o0, tbl[i].d0});
        check($sformatf("vec%0d last", i), wq[wq.size()-1], {1'b0, tbl[i].o1, tbl[i].d1});
      end
      check($sformatf("vec%0d err_cnt", i), err_cnt, exp_err);
    end

    // Short frame is dropped.
    d0 = done_cnt;
    vs_pulse();
    bad();
    check("drop6 frame_done", done_cnt - d0, 0);
    check("drop6 frame_sel", frame_sel, 1);
    check("drop6 err_cnt", err_cnt, exp_err);

    // vs and hs rising together: hs ignored, so no flush of the 3 pending pixels.
    mark = wq.size();
    pixels(3, 2);
    vs = 1'b1; hs = 1'b1; tick();
    vs = 1'b0; hs = 1'b0; tick(); tick();
    bad();
    check("vs+hs writes", wq.size() - mark, 0);
    check("vs+hs err_cnt", err_cnt, exp_err);
    mark = wq.size();
    line(4, 1);
    bad();
    check("vs+hs next write", (wq.size() > mark) ? wq[mark] : 22'h3FFFFF, {14'd0, 8'h55});
    vs_pulse();
    bad();

    // 100 full lines then vs: frame dropped, next frame restarts at offset 0.
    for (int l = 0; l < 100; l++) line(160, -1);
    d0 = done_cnt;
    vs_pulse();
    bad();
    check("drop100 frame_done", done_cnt - d0, 0);
    check("drop100 frame_sel", frame_sel, 1);
    check("drop100 err_cnt", err_cnt, exp_err);
    mark = wq.size();
    line(4, 1);
    bad();
    check("drop100 restart", (wq.size() > mark) ? wq[mark] : 22'h3FFFFF, {14'd0, 8'h55});
    vs_pulse();
    bad();

    full_frame(1'b0);
    full_frame(1'b1);

    // Reset after 3 pixels: nothing written, outputs back to reset values.
    mark = wq.size();
    pixels(3, 1);
    rst = 1'b1;
    tick();
    exp_err = 8'd0;
    check("midline writes", wq.size() - mark, 0);
    check_reset_outputs("midline");
    rst = 1'b0;
    tick();
    vs_pulse();
    hs_pulse();
    check("post-reset writes", wq.size() - mark, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
